// File: rtl/rv64_mem_pkg.sv
// Shared constants and loader state type for the RV64 memory subsystem.
package rv64_mem_pkg;

  localparam int DATA_WIDTH = 64;
  localparam int IMEM_AW    = 10;
  localparam int DMEM_AW    = 10;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  typedef enum logic [0:0] {
    LOAD = 1'b0,
    DONE = 1'b1
  } loader_state_e;

endpackage

// File: rtl/imem_loader.sv
// Streaming IMEM loader: accepts words until the last-marked word or a full
// image, then holds a registered done flag until the next reset.
module imem_loader
  import rv64_mem_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               load_valid,
  input  logic               load_last,
  output logic               imem_we,
  output logic [IMEM_AW-1:0] imem_waddr,
  output logic [IMEM_AW:0]   loaded_cnt,
  output logic               done
);

  loader_state_e      state_r;
  loader_state_e      state_nxt_s;
  logic [IMEM_AW-1:0] load_ptr_r;
  logic [IMEM_AW-1:0] load_ptr_nxt_s;
  logic [IMEM_AW:0]   loaded_cnt_r;
  logic [IMEM_AW:0]   loaded_cnt_nxt_s;
  logic               done_r;
  logic               done_nxt_s;
  logic               accept_s;
  logic               full_s;

  assign accept_s = (state_r == LOAD) && load_valid;
  assign full_s   = (load_ptr_r == {IMEM_AW{1'b1}});

  // Next-state logic; the pointer saturates at the top entry instead of wrapping
  always_comb begin
    state_nxt_s      = state_r;
    load_ptr_nxt_s   = load_ptr_r;
    loaded_cnt_nxt_s = loaded_cnt_r;
    done_nxt_s       = done_r;
    case (state_r)
      LOAD: begin
        if (accept_s) begin
          loaded_cnt_nxt_s = loaded_cnt_r + (IMEM_AW+1)'(1);
          if (load_last || full_s) begin
            state_nxt_s = DONE;
            done_nxt_s  = 1'b1;
          end else begin
            load_ptr_nxt_s = load_ptr_r + IMEM_AW'(1);
          end
        end else begin
          state_nxt_s = LOAD;
        end
      end
      DONE: begin
        state_nxt_s = DONE;
        done_nxt_s  = 1'b1;
      end
      default: begin
        state_nxt_s = LOAD;
        done_nxt_s  = 1'b0;
      end
    endcase
  end

  // Loader state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= LOAD;
      load_ptr_r   <= '0;
      loaded_cnt_r <= '0;
      done_r       <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      load_ptr_r   <= load_ptr_nxt_s;
      loaded_cnt_r <= loaded_cnt_nxt_s;
      done_r       <= done_nxt_s;
    end
  end

  assign imem_we    = accept_s;
  assign imem_waddr = load_ptr_r;
  assign loaded_cnt = loaded_cnt_r;
  assign done       = done_r;

endmodule

// File: rtl/rv64_mem_subsys.sv
// Instruction memory with streaming loader plus 64-bit data memory; both
// read combinationally and write on the rising clock edge.
module rv64_mem_subsys
  import rv64_mem_pkg::*;
(
  input  logic                  in_Clk,
  input  logic                  Rst,
  input  logic                  in_load_valid,
  input  logic [31:0]           in_load_data,
  input  logic                  in_load_last,
  output logic                  out_done_load_inst,
  input  logic [DATA_WIDTH-1:0] in_inst_addr,
  output logic [31:0]           out_inst,
  input  logic [DATA_WIDTH-1:0] in_addr,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_wr_en,
  output logic [DATA_WIDTH-1:0] out_data
);

  localparam int IMEM_DEPTH = 1 << IMEM_AW;
  localparam int DMEM_DEPTH = 1 << DMEM_AW;

  logic [31:0]           imem_r [0:IMEM_DEPTH-1];
  logic [DATA_WIDTH-1:0] dmem_r [0:DMEM_DEPTH-1];

  logic               imem_we_s;
  logic [IMEM_AW-1:0] imem_waddr_s;
  logic [IMEM_AW:0]   loaded_cnt_s;
  logic               done_s;

  logic [IMEM_AW-1:0] fetch_idx_s;
  logic               fetch_ok_s;
  logic [DMEM_AW-1:0] dmem_idx_s;
  logic               dmem_in_range_s;
  logic               unused_addr_bits_s;

  imem_loader u_loader (
    .clk        (in_Clk),
    .rst        (Rst),
    .load_valid (in_load_valid),
    .load_last  (in_load_last),
    .imem_we    (imem_we_s),
    .imem_waddr (imem_waddr_s),
    .loaded_cnt (loaded_cnt_s),
    .done       (done_s)
  );

  assign out_done_load_inst = done_s;

  // Byte-offset bits are intentionally don't-care: accesses are word aligned
  assign unused_addr_bits_s = ^{in_inst_addr[1:0], in_addr[2:0]};

  assign fetch_idx_s = in_inst_addr[IMEM_AW+1:2];
  assign fetch_ok_s  = done_s
                     && (in_inst_addr[DATA_WIDTH-1:IMEM_AW+2] == (DATA_WIDTH-IMEM_AW-2)'(0))
                     && ({1'b0, fetch_idx_s} < loaded_cnt_s);

  // Instruction fetch; anything not yet loaded reads as a NOP
  always_comb begin
    out_inst = NOP_INST;
    if (fetch_ok_s) begin
      out_inst = imem_r[fetch_idx_s];
    end else begin
      out_inst = NOP_INST;
    end
  end

  assign dmem_idx_s      = in_addr[DMEM_AW+2:3];
  assign dmem_in_range_s = (in_addr[DATA_WIDTH-1:DMEM_AW+3] == (DATA_WIDTH-DMEM_AW-3)'(0));

  // Data read without write bypass; out-of-range addresses read as zero
  always_comb begin
    out_data = {DATA_WIDTH{1'b0}};
    if (dmem_in_range_s) begin
      out_data = dmem_r[dmem_idx_s];
    end else begin
      out_data = {DATA_WIDTH{1'b0}};
    end
  end

  // Memory arrays keep their contents across reset
  always_ff @(posedge in_Clk) begin
    if (imem_we_s) begin
      imem_r[imem_waddr_s] <= in_load_data;
    end
    if (in_wr_en && dmem_in_range_s) begin
      dmem_r[dmem_idx_s] <= in_data;
    end
  end

endmodule

// File: tb/tb_rv64_mem_subsys.sv
// Directed plus randomized bench for rv64_mem_subsys against a queue/array model.
module tb_rv64_mem_subsys;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        in_Clk = 1'b0;
  logic        Rst = 1'b1;
  logic        in_load_valid = 1'b0;
  logic [31:0] in_load_data = 32'h0;
  logic        in_load_last = 1'b0;
  logic        out_done_load_inst;
  logic [63:0] in_inst_addr = 64'h0;
  logic [31:0] out_inst;
  logic [63:0] in_addr = 64'h0;
  logic [63:0] in_data = 64'h0;
  logic        in_wr_en = 1'b0;
  logic [63:0] out_data;

  int n_cmp = 0;
  int n_mis = 0;

  // Reference model: loaded instruction words in order, done flag, written data words
  logic [31:0] m_imem [$];
  bit          m_done = 1'b0;
  logic [63:0] m_dmem [longint unsigned];

  rv64_mem_subsys dut (
    .in_Clk             (in_Clk),
    .Rst                (Rst),
    .in_load_valid      (in_load_valid),
    .in_load_data       (in_load_data),
    .in_load_last       (in_load_last),
    .out_done_load_inst (out_done_load_inst),
    .in_inst_addr       (in_inst_addr),
    .out_inst           (out_inst),
    .in_addr            (in_addr),
    .in_data            (in_data),
    .in_wr_en           (in_wr_en),
    .out_data           (out_data)
  );

  always #50 in_Clk = ~in_Clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock edge; the model absorbs whatever the inputs present at that edge
  task automatic step();
    @(posedge in_Clk);
    if (!Rst) begin
      if (in_load_valid && !m_done) begin
        m_imem.push_back(in_load_data);
        if (in_load_last || m_imem.size() == 1024) m_done = 1'b1;
      end
      if (in_wr_en && in_addr < 64'h2000) m_dmem[in_addr >> 3] = in_data;
    end
    #1;
  endtask

  task automatic idle();
    in_load_valid = 1'b0;
    in_load_last  = 1'b0;
    in_wr_en      = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    Rst = 1'b1;
    m_imem.delete();
    m_done = 1'b0;
    repeat (2) @(posedge in_Clk);
    #1;
    chk("reset_done_low", {63'h0, out_done_load_inst}, 64'h0);
    Rst = 1'b0;
    #1;
  endtask

  function automatic logic [31:0] exp_inst(input logic [63:0] a);
    if (m_done && a < 64'd4096 && (a >> 2) < m_imem.size()) return m_imem[a >> 2];
    return NOP;
  endfunction

  task automatic check_fetch(input string tag, input logic [63:0] a);
    in_inst_addr = a;
    #1;
    chk(tag, {32'h0, out_inst}, {32'h0, exp_inst(a)});
  endtask

  // Only addresses the model knows are compared; unwritten words are undefined
  task automatic check_data(input string tag, input logic [63:0] a);
    in_addr = a;
    #1;
    if (a >= 64'h2000) chk(tag, out_data, 64'h0);
    else if (m_dmem.exists(a >> 3)) chk(tag, out_data, m_dmem[a >> 3]);
  endtask

  initial begin
    logic [31:0] prog [4];
    logic [63:0] a;
    prog[0] = 32'h0050_0093; prog[1] = 32'h00A0_0113;
    prog[2] = 32'h0020_81B3; prog[3] = 32'h0000_0013;

    repeat (3) @(posedge in_Clk);
    #1;
    chk("rst_done", {63'h0, out_done_load_inst}, 64'h0);
    check_fetch("rst_fetch", 64'h0);
    Rst = 1'b0;
    #1;

    // in_load_last without valid must not finish the load
    in_load_last = 1'b1;
    step();
    idle();
    chk("last_no_valid", {63'h0, out_done_load_inst}, 64'h0);

    for (int i = 0; i < 4; i++) begin
      in_load_valid = 1'b1;
      in_load_data  = prog[i];
      in_load_last  = (i == 3);
      check_fetch("fetch_before_done", 64'h0);
      chk("done_before_last", {63'h0, out_done_load_inst}, 64'h0);
      step();
    end
    idle();
    chk("done_after_last", {63'h0, out_done_load_inst}, 64'h1);
    chk("fetch_0x8_const", {32'h0, out_inst}, {32'h0, exp_inst(64'h0)});
    check_fetch("fetch_0x8", 64'h8);
    chk("fetch_0x8_value", {32'h0, out_inst}, 64'h0020_81B3);
    check_fetch("fetch_0xA", 64'hA);
    check_fetch("fetch_0x4", 64'h4);
    check_fetch("fetch_0x10", 64'h10);
    check_fetch("fetch_upper", 64'h1000_0000_0000_0000);

    // DMEM write latency and no bypass
    in_addr = 64'h18; in_data = 64'h1111_2222_3333_4444; in_wr_en = 1'b1;
    step();
    in_data = 64'hDEAD_BEEF_CAFE_F00D;
    #1;
    chk("dmem_old_before_edge", out_data, 64'h1111_2222_3333_4444);
    step();
    idle();
    check_data("dmem_0x18", 64'h18);
    check_data("dmem_0x1F", 64'h1F);
    chk("dmem_0x1F_value", out_data, 64'hDEAD_BEEF_CAFE_F00D);

    // Out-of-range write aliasing onto word 3 must be dropped
    in_addr = 64'h8000_0000_0000_0018; in_data = 64'h0123_4567_89AB_CDEF; in_wr_en = 1'b1;
    #1;
    chk("oor_read_pre", out_data, 64'h0);
    step();
    idle();
    check_data("oor_read_post", 64'h8000_0000_0000_0018);
    check_data("dmem_0x18_kept", 64'h18);

    // Randomized data traffic and fetches
    for (int i = 0; i < 60; i++) begin
      a = {59'(0), 5'($urandom_range(0, 31))} << 3;
      a = a | 64'($urandom_range(0, 7));
      if ($urandom_range(0, 7) == 0) a[13 + $urandom_range(0, 50)] = 1'b1;
      in_data  = {$urandom, $urandom};
      in_wr_en = ($urandom_range(0, 1) == 1);
      check_data("rand_dmem_pre", a);
      step();
      in_wr_en = 1'b0;
      check_data("rand_dmem_post", a);
      check_fetch("rand_fetch", 64'($urandom_range(0, 31)));
    end
    idle();

    // Reset keeps memory, clears loader; mid-load reset restarts from index 0
    do_reset();
    check_data("dmem_after_reset", 64'h18);
    for (int i = 0; i < 2; i++) begin
      in_load_valid = 1'b1; in_load_data = $urandom; in_load_last = 1'b0;
      step();
    end
    idle();
    chk("partial_done", {63'h0, out_done_load_inst}, 64'h0);
    check_fetch("partial_fetch", 64'h0);
    do_reset();
    for (int i = 0; i < 4; i++) begin
      in_load_valid = 1'b1; in_load_data = $urandom; in_load_last = (i == 3);
      step();
    end
    idle();
    chk("reload_done", {63'h0, out_done_load_inst}, 64'h1);
    for (int i = 0; i < 5; i++) check_fetch("reload_fetch", 64'(i * 4));

    // Full image without a last marker
    do_reset();
    for (int i = 0; i < 1024; i++) begin
      in_load_valid = 1'b1; in_load_data = $urandom; in_load_last = 1'b0;
      if (i == 1023) chk("full_done_pre", {63'h0, out_done_load_inst}, 64'h0);
      step();
    end
    chk("full_done", {63'h0, out_done_load_inst}, 64'h1);
    for (int i = 0; i < 3; i++) begin
      in_load_valid = 1'b1; in_load_data = $urandom; in_load_last = 1'b1;
      step();
    end
    idle();
    chk("full_count", 64'(m_imem.size()), 64'd1024);
    check_fetch("full_first", 64'h0);
    check_fetch("full_last", 64'hFFC);
    check_fetch("full_last_unaligned", 64'hFFF);
    check_fetch("full_past_end", 64'h1000);
    for (int i = 0; i < 20; i++) check_fetch("full_rand", 64'($urandom_range(0, 4095)));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
